// File: rtl/mnist_pkg.sv
// Shared definitions for the MNIST result unit: register map, status bit
// positions, controller states and default datapath sizes.
`timescale 1ns/1ps
package mnist_pkg;

    // Default datapath sizes
    localparam int DEF_NUM_CLASSES = 10;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_IDX_W       = 4;

    // Byte offsets inside the 16-byte register window
    localparam logic [3:0] OFF_CTRL     = 4'h0;
    localparam logic [3:0] OFF_RESULT   = 4'h4;
    localparam logic [3:0] OFF_MAXSCORE = 4'h8;
    localparam logic [3:0] OFF_CYCLES   = 4'hC;

    // Bit positions in the CTRL/STATUS read word
    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_STOP1 = 2;

    // stop2 comes from registered ROM data in the controller and can still
    // show the previous run's value for this many cycles after the restart.
    localparam int STOP2_BLANK = 2;

    // Result unit controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mnist_argmax_scan.sv
// Streaming signed argmax tracker. One score per enabled cycle; the first
// score (load) is taken unconditionally, later ones only when strictly
// greater, so ties keep the lowest index. 'complete' latches on the last one.
`timescale 1ns/1ps
module mnist_argmax_scan
    import mnist_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = DEF_IDX_W
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     clear,
    input  logic                     en,
    input  logic                     load,
    input  logic                     last,
    input  logic signed [DATA_W-1:0] score,
    input  logic        [IDX_W-1:0]  index,
    output logic signed [DATA_W-1:0] max_score,
    output logic        [IDX_W-1:0]  max_index,
    output logic                     complete
);

    logic better;

    // Full-width signed compare; load forces the first score in
    assign better = load || (score > max_score);

    // Running maximum, its index and the end-of-scan flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            max_score <= '0;
            max_index <= '0;
            complete  <= 1'b0;
        end else if (clear) begin
            max_score <= '0;
            max_index <= '0;
            complete  <= 1'b0;
        end else if (en) begin
            if (better) begin
                max_score <= score;
                max_index <= index;
            end
            if (last) begin
                complete <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mnist_result_unit.sv
// MNIST result unit: PicoRV32 memory-mapped peripheral that restarts the
// accelerator, times the run until layer 2 finishes, then reads the class
// scores serially and reports the signed argmax.
`timescale 1ns/1ps
module mnist_result_unit
    import mnist_pkg::*;
#(
    parameter int          NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int          DATA_W      = DEF_DATA_W,
    parameter int          IDX_W       = DEF_IDX_W,
    parameter logic [31:0] BASE_ADDR   = 32'h0300_0000
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     mem_valid,
    input  logic [31:0]              mem_addr,
    input  logic [31:0]              mem_wdata,
    input  logic [3:0]               mem_wstrb,
    output logic                     mem_ready,
    output logic [31:0]              mem_rdata,
    input  logic                     stop1,
    input  logic                     stop2,
    output logic                     acc_reset,
    output logic [IDX_W-1:0]         score_addr,
    input  logic signed [DATA_W-1:0] score_data
);

    localparam int               CNT_W     = $clog2(NUM_CLASSES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_CLASSES);
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(NUM_CLASSES - 1);

    // Saturating cycle counter step
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t                     state;
    logic                       busy;
    logic [31:0]                cycles;
    logic [CNT_W-1:0]           scan_cnt;
    logic                       acked;

    logic                       hit;
    logic                       accept;
    logic [3:0]                 reg_off;
    logic                       start_req;
    logic                       stop2_armed;

    logic                       scan_clear;
    logic                       scan_en;
    logic                       scan_load;
    logic                       scan_last;
    logic [IDX_W-1:0]           scan_index;
    logic signed [DATA_W-1:0]   max_score;
    logic [IDX_W-1:0]           max_index;
    logic                       done;

    logic [31:0]                status;
    logic [31:0]                read_word;
    logic                       unused_bus;

    assign unused_bus = ^{mem_addr[1:0], mem_wdata[31:1]};

    // Bus decode: one acknowledge per request, re-armed once mem_valid drops
    assign hit       = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign accept    = hit && !acked;
    assign reg_off   = {mem_addr[3:2], 2'b00};
    assign start_req = accept && (reg_off == OFF_CTRL) && mem_wstrb[0] && mem_wdata[0];

    // After the restart pulse stop2 may be stale; only trust it later on
    assign stop2_armed = (cycles > 32'(STOP2_BLANK));

    // Scan cycle t presents address t; its datum returns in cycle t+1
    assign scan_clear = start_req && ((state == IDLE) || (state == DONE));
    assign scan_en    = (state == SCAN) && (scan_cnt != '0);
    assign scan_load  = (scan_cnt == CNT_W'(1));
    assign scan_last  = (scan_cnt == LAST_CNT);
    assign scan_index = IDX_W'(scan_cnt - 1'b1);

    // Controller: restart pulse, run timing, score address sequencing
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            busy       <= 1'b0;
            acc_reset  <= 1'b0;
            cycles     <= '0;
            scan_cnt   <= '0;
            score_addr <= '0;
        end else begin
            acc_reset <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_req) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        acc_reset <= 1'b1;
                        cycles    <= '0;
                    end
                end
                RUN: begin
                    if (stop2 && stop2_armed) begin
                        state      <= SCAN;
                        scan_cnt   <= '0;
                        score_addr <= '0;
                    end else begin
                        cycles <= sat_inc(cycles);
                    end
                end
                SCAN: begin
                    scan_cnt <= scan_cnt + 1'b1;
                    if (scan_cnt < LAST_ADDR) begin
                        score_addr <= IDX_W'(scan_cnt + 1'b1);
                    end
                    if (scan_last) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        score_addr <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mnist_argmax_scan #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_argmax (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (scan_clear),
        .en        (scan_en),
        .load      (scan_load),
        .last      (scan_last),
        .score     (score_data),
        .index     (scan_index),
        .max_score (max_score),
        .max_index (max_index),
        .complete  (done)
    );

    // Register read multiplexer
    always_comb begin
        status             = '0;
        status[STAT_BUSY]  = busy;
        status[STAT_DONE]  = done;
        status[STAT_STOP1] = stop1;
        read_word          = '0;
        case (reg_off)
            OFF_CTRL:     read_word = status;
            OFF_RESULT:   read_word = {{(32-IDX_W){1'b0}}, max_index};
            OFF_MAXSCORE: read_word = 32'(max_score);
            OFF_CYCLES:   read_word = cycles;
            default:      read_word = '0;
        endcase
    end

    // Bus response: single-cycle ready, read data only on reads
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            acked     <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            if (accept) begin
                mem_ready <= 1'b1;
                acked     <= 1'b1;
                if (mem_wstrb == 4'b0000) begin
                    mem_rdata <= read_word;
                end
            end else if (!mem_valid) begin
                acked <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mnist_result_unit.sv
// Directed bench for mnist_result_unit: table of score sets with expected
// argmax, plus hand sequences for busy restart, stale stop2 and mid-scan reset.
`timescale 1ns/1ps
module tb_mnist_result_unit;

    localparam logic [31:0] BASE = 32'h0300_0000;

    typedef struct packed {
        logic [0:9][31:0] sc;
        logic [31:0]      stop_at;
        logic             stop1;
        logic [31:0]      exp_idx;
        logic [31:0]      exp_max;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stop1;
    logic        stop2;
    logic        acc_reset;
    logic [3:0]  score_addr;
    logic [31:0] score_data;

    logic [31:0] mem_scores [10];
    vec_t        vecs [5];
    int          t [10];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc       = 0;
    int pulse_cnt = 0;
    int pulse_cyc = 0;

    logic [31:0] d;
    int          lat;
    int          cnt;
    int          prev;

    always #5 clk = ~clk;

    mnist_result_unit dut (
        .clk        (clk),
        .resetn     (resetn),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .stop1      (stop1),
        .stop2      (stop2),
        .acc_reset  (acc_reset),
        .score_addr (score_addr),
        .score_data (score_data)
    );

    // Score buffer model with one-cycle read latency
    always @(posedge clk)
        score_data <= (score_addr < 4'd10) ? mem_scores[score_addr] : 32'h0;

    // Cycle counter and restart pulse monitor
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (acc_reset) begin
            pulse_cnt = pulse_cnt + 1;
            pulse_cyc = cyc;
        end
    end

    function automatic logic [0:9][31:0] pack10(input int a [10]);
        logic [0:9][31:0] r;
        for (int i = 0; i < 10; i++) r[i] = a[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                       output logic [31:0] rdata, output int latency);
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        mem_valid = 1'b1;
        latency   = -1;
        rdata     = '0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                latency = i;
                rdata   = mem_rdata;
                break;
            end
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
        @(posedge clk); #1;
        if (latency < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL bus_timeout: addr 0x%08h got no ready, expected ready within 8 cycles", addr);
        end
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] rdata);
        int l;
        bus(addr, 32'h0, 4'b0000, rdata, l);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        logic [31:0] dummy;
        int l;
        bus(addr, wdata, wstrb, dummy, l);
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 5000 && cyc < target; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic load_scores(input int v);
        for (int k = 0; k < 10; k++) mem_scores[k] = vecs[v].sc[k];
    endtask

    // Issue a start command and wait for the restart pulse to be seen
    task automatic start_cmd(output int p);
        p = pulse_cnt;
        wr(BASE + 32'h0, 32'h1, 4'hF);
        for (int i = 0; i < 10 && pulse_cnt == p; i++) begin
            @(posedge clk); #1;
        end
        check("start_pulse_seen", 32'(pulse_cnt - p), 32'd1);
    endtask

    // Raise stop2 so that it is first sampled n cycles after the pulse cycle
    task automatic stop2_at(input int n);
        wait_cyc(pulse_cyc + n - 1);
        stop2 = 1'b1;
    endtask

    task automatic finish_check(input string tag, input int v, input int n, input int p);
        logic [31:0] r;
        bit          seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            rd(BASE + 32'h0, r);
            if (r[1]) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_done_timeout: done bit never set, expected set within 40 polls", tag);
        end
        check($sformatf("%s_pulses", tag), 32'(pulse_cnt - p), 32'd1);
        rd(BASE + 32'h4, r);
        check($sformatf("%s_result", tag), r, vecs[v].exp_idx);
        rd(BASE + 32'h8, r);
        check($sformatf("%s_maxscore", tag), r, vecs[v].exp_max);
        rd(BASE + 32'hC, r);
        check($sformatf("%s_cycles", tag), r, 32'(n));
        rd(BASE + 32'h0, r);
        check($sformatf("%s_status", tag), r, {29'b0, stop1, 1'b1, 1'b0});
    endtask

    initial begin
        // Vector table: scores, stop2 delay, stop1 level, expected argmax
        t = '{5, -3, 17, 2, 17, 0, -100, 9, 16, 1};
        vecs[0] = {pack10(t), 32'd800, 1'b1, 32'd2, 32'd17};
        t = '{-9, -8, -7, -6, -5, -4, -3, -2, -1, -1};
        vecs[1] = {pack10(t), 32'd20, 1'b0, 32'd8, 32'hFFFF_FFFF};
        t = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        vecs[2] = {pack10(t), 32'd5, 1'b1, 32'd9, 32'd10};
        t = '{int'(32'h8000_0000), 65535, 65536, -1, 0, 2147483646, 2147483647,
              -2147483647, 7, 2147483647};
        vecs[3] = {pack10(t), 32'd12, 1'b1, 32'd6, 32'h7FFF_FFFF};
        t = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[4] = {pack10(t), 32'd3, 1'b0, 32'd0, 32'd0};

        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        stop1     = 1'b0;
        stop2     = 1'b0;
        for (int k = 0; k < 10; k++) mem_scores[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_acc_reset", {31'b0, acc_reset}, 32'd0);
        check("reset_mem_ready", {31'b0, mem_ready}, 32'd0);
        check("reset_score_addr", {28'b0, score_addr}, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Reset state through the bus
        bus(BASE + 32'h0, 32'h0, 4'b0000, d, lat);
        check("reset_status", d, 32'd0);
        check("ready_latency", 32'(lat), 32'd1);
        rd(BASE + 32'h4, d);
        check("reset_result", d, 32'd0);
        rd(BASE + 32'h8, d);
        check("reset_maxscore", d, 32'd0);
        rd(BASE + 32'hC, d);
        check("reset_cycles", d, 32'd0);

        // mem_valid held high: exactly one ready pulse
        mem_addr = BASE + 32'h8; mem_wstrb = 4'b0000; mem_valid = 1'b1; cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (mem_ready) cnt++;
        end
        mem_valid = 1'b0;
        @(posedge clk); #1;
        check("ready_single_pulse", 32'(cnt), 32'd1);

        // Address outside the window is never acknowledged
        mem_addr = BASE + 32'h10; mem_valid = 1'b1; cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (mem_ready) cnt++;
        end
        mem_valid = 1'b0;
        @(posedge clk); #1;
        check("out_of_window_ready", 32'(cnt), 32'd0);

        // Table-driven runs
        for (int v = 0; v < 5; v++) begin
            stop2 = 1'b0;
            stop1 = vecs[v].stop1;
            load_scores(v);
            start_cmd(prev);
            stop2_at(int'(vecs[v].stop_at));
            finish_check($sformatf("vec%0d", v), v, int'(vecs[v].stop_at), prev);
        end

        // Writes to RESULT/MAXSCORE/CYCLES are ignored
        wr(BASE + 32'h4, 32'hFFFF_FFFF, 4'hF);
        wr(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF);
        wr(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
        rd(BASE + 32'h4, d);
        check("ignored_wr_result", d, 32'd0);
        rd(BASE + 32'h8, d);
        check("ignored_wr_maxscore", d, 32'd0);
        rd(BASE + 32'hC, d);
        check("ignored_wr_cycles", d, 32'd3);

        // CTRL write without wstrb[0] does not start
        prev = pulse_cnt;
        wr(BASE + 32'h0, 32'hFFFF_FFFF, 4'b1110);
        repeat (4) @(posedge clk);
        #1;
        check("partial_strobe_pulses", 32'(pulse_cnt - prev), 32'd0);
        rd(BASE + 32'h0, d);
        check("partial_strobe_status", d, 32'd2);

        // Start while busy: ignored, cycle count uninterrupted
        stop2 = 1'b0;
        stop1 = 1'b0;
        load_scores(0);
        start_cmd(prev);
        rd(BASE + 32'h0, d);
        check("busy_status", d, 32'd1);
        wr(BASE + 32'h0, 32'h1, 4'hF);
        stop2_at(100);
        finish_check("busy_restart", 0, 100, prev);

        // Stale stop2 high for the first cycles after the restart
        load_scores(1);
        start_cmd(prev);
        wait_cyc(pulse_cyc + 2);
        stop2 = 1'b0;
        stop2_at(40);
        finish_check("stale_stop2", 1, 40, prev);

        // Reset during SCAN, then a clean run
        stop2 = 1'b0;
        load_scores(2);
        start_cmd(prev);
        stop2_at(30);
        wait_cyc(pulse_cyc + 33);
        resetn = 1'b0;
        #1;
        check("midscan_reset_acc", {31'b0, acc_reset}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        stop2  = 1'b0;
        @(posedge clk); #1;
        check("midscan_reset_pulses", 32'(pulse_cnt - prev), 32'd1);
        rd(BASE + 32'h0, d);
        check("midscan_status", d, 32'd0);
        rd(BASE + 32'h4, d);
        check("midscan_result", d, 32'd0);
        rd(BASE + 32'h8, d);
        check("midscan_maxscore", d, 32'd0);
        rd(BASE + 32'hC, d);
        check("midscan_cycles", d, 32'd0);
        load_scores(0);
        start_cmd(prev);
        stop2_at(10);
        finish_check("after_reset", 0, 10, prev);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mnist_result_unit.md
Name: mnist_result_unit

Overview:
- Downstream of the accelerator controller: waits for layer-2 completion (stop2), serially reads the NUM_CLASSES output scores, and computes the signed argmax (predicted digit).
- Exposes start/status/result to PicoRV32 as a memory-mapped peripheral on the native mem_* bus.
- Restarts the accelerator by pulsing its active-high reset/start input on a CPU start command.

Parameters:
- NUM_CLASSES, 10, number of layer-2 output scores.
- DATA_W, 32, score width, signed two's complement.
- IDX_W, 4, width of class index and score address.
- BASE_ADDR, 32'h0300_0000, 16-byte register window base.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- mem_valid  in  1  PicoRV32 bus request.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte strobes; 0 = read.
- mem_ready  out  1  one-cycle acknowledge.
- mem_rdata  out  32  read data, valid with mem_ready.
- stop1  in  1  layer-1 done, level.
- stop2  in  1  layer-2 done, level.
- acc_reset  out  1  active-high restart pulse to the accelerator controller.
- score_addr  out  IDX_W  score buffer read address.
- score_data  in  DATA_W  score read data, one-cycle latency.

Behaviour:
- Reset (async, resetn=0): state IDLE; acc_reset=0, mem_ready=0, mem_rdata=0, score_addr=0; busy=0, done=0; result=0, max=0, cycles=0.
- Address hit: mem_valid && mem_addr[31:4]==BASE_ADDR[31:4]. mem_ready rises the cycle after the hit, stays high exactly 1 cycle, and is not reasserted until mem_valid has dropped.
- Register map (offset mem_addr[3:2]):
  - 0x0 CTRL/STATUS. Write with wdata[0]=1 requests start. Read returns {29'b0, stop1, done, busy}.
  - 0x4 RESULT: {28'b0, class index}.
  - 0x8 MAXSCORE: signed winning score.
  - 0xC CYCLES: clk count from the acc_reset pulse to the stop2 detect, saturating at 32'hFFFF_FFFF.
  - Writes to 0x4–0xC are acknowledged and ignored. Partial strobes on CTRL act only if wstrb[0]=1.
- FSM states:
  - IDLE: on start request, go to RUN. Set busy=1, done=0; clear cycles, result and max; acc_reset=1 for exactly one cycle.
  - RUN: cycles increments every cycle. stop2 is ignored for the first 2 cycles after acc_reset (the controller's stop2 derives from registered ROM data). After that, stop2=1 moves to SCAN with score_addr=0.
  - SCAN: score_addr steps 0..NUM_CLASSES-1, one per cycle. The datum for address k is compared one cycle later. The first score loads max unconditionally. Later scores replace max/result only if strictly greater (signed), so ties keep the lowest index. After the last compare (NUM_CLASSES+1 cycles in SCAN), go to DONE.
  - DONE: busy=0, done=1. A start request re-enters RUN as from IDLE.
- A start request while busy (RUN/SCAN) is acknowledged but has no effect. No acc_reset, no state change.
- If resetn is asserted mid-operation, all state returns to reset values. The accelerator is not pulsed.
- Comparator: full DATA_W signed compare. No truncation.

Decomposition:
- Shared package mnist_pkg:
  - register offsets (CTRL=0x0, RESULT=0x4, MAXSCORE=0x8, CYCLES=0xC);
  - STATUS bit positions;
  - FSM state enum (IDLE, RUN, SCAN, DONE);
  - NUM_CLASSES/DATA_W defaults.
- One natural sub-module: mnist_argmax_scan (streaming signed max/index tracker with load/enable/last inputs).
- Bus decode/FSM stays in the top.

Test Plan:
- Reset, then read 0x0 and 0x4 -> both 0. mem_ready is high exactly 1 cycle after mem_valid.
- Write 0x0=1; stop2 rises 800 cycles after the acc_reset pulse. Scores {5,-3,17,2,17,0,-100,9,16,1} -> RESULT=2 (tie with index 4 keeps 2), MAXSCORE=17, CYCLES=800, STATUS=0b010 plus stop1.
- All scores negative {-9,-8,...,-1, -1 at index 9} -> RESULT=8, MAXSCORE=-1 (signed compare, first of tie).
- Write start while busy in RUN -> no second acc_reset pulse. CYCLES continues uninterrupted.
- stop2 already high at start (stale from the previous run) -> not detected within the first 2 cycles. SCAN begins only on genuine stop2 after restart.
- Deassert resetn during SCAN -> STATUS=0, RESULT=0 immediately. A subsequent start runs normally to DONE.
